// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit that owns the HI/LO
//               result registers. Signed and unsigned multiply (shift-add)
//               and divide (restoring shift-subtract). The unit has one
//               start/busy/done handshake, a flush input that aborts the
//               current operation, and direct HI/LO loads for MTHI/MTLO.
//
// Ports
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   start     : launch an operation (sampled only in IDLE)
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      : multiplicand/dividend and multiplier/divisor
//   flush     : abort any in-flight operation
//   hi_load   : write wdata into HI (IDLE only)
//   lo_load   : write wdata into LO (IDLE only)
//   wdata     : HI/LO direct-write data
//   busy      : high whenever the unit is not IDLE
//   done      : one-cycle pulse on result commit or divide-by-zero
//   div_zero  : one-cycle pulse with done on a divide with b == 0
//   hi, lo    : product high/low halves, or remainder/quotient
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_load,
    input  logic             lo_load,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_opnd_b;   // |b|: multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;      // {upper/remainder, lower/multiplier/quotient}
    logic                 r_neg_q;    // product or quotient needs negation
    logic                 r_neg_r;    // remainder needs negation
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_div_zero;

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    logic                 w_is_div;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_abs_a  = (w_signed && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_abs_b  = (w_signed && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right. The
    // carry out of the add becomes the new MSB so nothing is lost.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_opnd_b : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Divide step: shift the next dividend bit into the partial remainder
    // and try a subtract. The remainder is always below the divisor, so
    // the shifted value is below 2*divisor and a non-negative difference
    // always fits in WIDTH bits.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_sub;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_rem_new;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_rem_sub  = w_rem_sh - {1'b0, r_opnd_b};
    assign w_q_bit    = ~w_rem_sub[WIDTH];
    assign w_rem_new  = w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_q_bit};

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                            : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_opnd_b   <= '0;
            r_acc      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;

            if (r_state == S_IDLE) begin
                // Loads apply even when a start is accepted on the same edge;
                // the result written in FIX later overwrites them.
                if (hi_load) begin
                    r_hi <= wdata;
                end
                if (lo_load) begin
                    r_lo <= wdata;
                end
                if (start && !flush) begin
                    if (op[1] && (b == '0)) begin
                        r_done     <= 1'b1;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= S_PREP;
                    end
                end
            end else if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_PREP: begin
                        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_opnd_b <= w_abs_b;
                        r_neg_q  <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_r  <= w_signed & w_is_div & r_a[WIDTH-1];
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                    S_RUN: begin
                        r_acc <= w_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (w_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit. Stimulus pushes the
//               hand-computed result and the cycle it is due into a queue;
//               monitors pop and compare whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        hi_load = 1'b0;
    logic        lo_load = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32;
    exp_t e8;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_load(hi_load), .lo_load(lo_load), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(1'b0), .hi_load(1'b0), .lo_load(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit instance
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("res_hi32", 64'(hi), 64'(e32.hi));
                chk("res_lo32", 64'(lo), 64'(e32.lo));
                chk("res_dz32", 64'(div_zero), 64'(e32.dz));
                chk("res_cycle32", 64'(cyc), 64'(e32.due));
            end
        end
    end

    // Monitor for the 8-bit instance
    always @(posedge clk) begin
        #1;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("res_hi8", 64'(hi8), 64'(e8.hi));
                chk("res_lo8", 64'(lo8), 64'(e8.lo));
                chk("res_dz8", 64'(dz8), 64'(e8.dz));
                chk("res_cycle8", 64'(cyc), 64'(e8.due));
            end
        end
    end

    // Start an operation on the 32-bit unit; operands are scrambled right
    // after the accepting edge.
    task automatic issue32(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [31:0] eh, input logic [31:0] el, input logic edz,
                           input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (push) q32.push_back('{hi: eh, lo: el, dz: edz, due: cyc + 1 + (edz ? 0 : 34)});
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q8.size() == 0) break;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            chk("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
            q32.delete();
            q8.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Signed / unsigned multiply and divide
        issue32(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        wait_drain();
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
        wait_drain();
        issue32(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
        wait_drain();
        issue32(2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b1);
        wait_drain();
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
        wait_drain();

        // Direct loads, then divide by zero leaves HI/LO alone
        @(negedge clk); hi_load = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_load = 1'b0; lo_load = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_load = 1'b0;
        chk("load_hi", 64'(hi), 64'h11);
        chk("load_lo", 64'(lo), 64'h22);
        issue32(2'b10, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b1);
        chk("dz_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("dz_done_width", 64'(done), 64'd0);
        chk("dz_busy2", 64'(busy), 64'd0);
        wait_drain();

        // Flush mid-operation: no done, HI/LO untouched
        issue32(2'b00, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'h11);
        chk("flush_lo", 64'(lo), 64'h22);
        repeat (45) @(negedge clk);

        // Start while busy is ignored; load while busy is ignored
        issue32(2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
        lo_load = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; lo_load = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Load accepted on the same edge as start; result overwrites it
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        hi_load = 1'b1; wdata = 32'h55;
        q32.push_back('{hi: 32'h0, lo: 32'd12, dz: 1'b0, due: cyc + 1 + 34});
        @(negedge clk);
        start = 1'b0; hi_load = 1'b0;
        chk("same_edge_load_hi", 64'(hi), 64'h55);
        wait_drain();

        // Asynchronous reset mid-run
        issue32(2'b00, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        // 8-bit instance: signed MIN*MIN
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
        q8.push_back('{hi: 32'h40, lo: 32'h00, dz: 1'b0, due: cyc + 1 + 10});
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
